// File: rtl/ram_port_arbiter_if.sv
// Strobe-style RAM bus between one master and the arbiter.
// addr/wdata/wmask/rstrb request a transfer; rdata/rbusy/wbusy report back to the master.
interface ram_port_arbiter_if #(
  parameter int ADDR_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] addr;
  logic [31:0]           wdata;
  logic [3:0]            wmask;
  logic                  rstrb;
  logic [31:0]           rdata;
  logic                  rbusy;
  logic                  wbusy;

  modport master (
    output addr, wdata, wmask, rstrb,
    input  rdata, rbusy, wbusy
  );

  modport slave (
    input  addr, wdata, wmask, rstrb,
    output rdata, rbusy, wbusy
  );
endinterface

// File: rtl/ram_port_arbiter.sv
// Two-master arbiter in front of a single-port synchronous RAM.
// Requests are latched per master, issued one at a time, and read data is returned in per-master registers.
module ram_port_arbiter #(
  parameter int ADDR_WIDTH     = 32,
  parameter bit FIXED_PRIORITY = 1'b0
) (
  input  logic                  clk,
  input  logic                  resetn,
  ram_port_arbiter_if.slave     m0,
  ram_port_arbiter_if.slave     m1,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [31:0]           ram_wdata,
  output logic [3:0]            ram_wmask,
  output logic                  ram_rstrb,
  input  logic [31:0]           ram_rdata
);

  typedef enum logic {IDLE, RESP} state_t;

  state_t                       state_q, state_d;
  logic                         resp_id_q, resp_id_d;
  logic                         last_grant_q, last_grant_d;
  logic [1:0]                   pend_valid_q, pend_valid_d;
  logic [1:0]                   pend_write_q, pend_write_d;
  logic [1:0][ADDR_WIDTH-1:0]   pend_addr_q, pend_addr_d;
  logic [1:0][31:0]             pend_wdata_q, pend_wdata_d;
  logic [1:0][3:0]              pend_wmask_q, pend_wmask_d;
  logic [1:0][31:0]             rdata_q, rdata_d;

  logic [1:0][ADDR_WIDTH-1:0]   m_addr;
  logic [1:0][31:0]             m_wdata;
  logic [1:0][3:0]              m_wmask;
  logic [1:0]                   m_strobe;
  logic                         winner;
  logic                         issue;

  assign m_addr   = {m1.addr, m0.addr};
  assign m_wdata  = {m1.wdata, m0.wdata};
  assign m_wmask  = {m1.wmask, m0.wmask};
  assign m_strobe = {m1.rstrb | (|m1.wmask), m0.rstrb | (|m0.wmask)};

  assign issue = (state_q == IDLE) && (pend_valid_q != 2'b00);

  // On contention the master that was not served last wins, unless master 0 has fixed priority.
  always_comb begin
    winner = 1'b0;
    if (pend_valid_q == 2'b11) begin
      winner = FIXED_PRIORITY ? 1'b0 : ~last_grant_q;
    end else begin
      winner = pend_valid_q[1];
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= IDLE;
      resp_id_q    <= 1'b0;
      last_grant_q <= 1'b1;
      pend_valid_q <= '0;
      pend_write_q <= '0;
      pend_addr_q  <= '0;
      pend_wdata_q <= '0;
      pend_wmask_q <= '0;
      rdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      resp_id_q    <= resp_id_d;
      last_grant_q <= last_grant_d;
      pend_valid_q <= pend_valid_d;
      pend_write_q <= pend_write_d;
      pend_addr_q  <= pend_addr_d;
      pend_wdata_q <= pend_wdata_d;
      pend_wmask_q <= pend_wmask_d;
      rdata_q      <= rdata_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    resp_id_d = resp_id_q;
    case (state_q)
      IDLE: begin
        if (issue && !pend_write_q[winner]) begin
          state_d   = RESP;
          resp_id_d = winner;
        end
      end
      RESP: state_d = IDLE;
    endcase
  end

  // A read entry stays pending through RESP so rbusy covers the whole round trip.
  always_comb begin
    pend_valid_d = pend_valid_q;
    pend_write_d = pend_write_q;
    pend_addr_d  = pend_addr_q;
    pend_wdata_d = pend_wdata_q;
    pend_wmask_d = pend_wmask_q;
    rdata_d      = rdata_q;
    last_grant_d = last_grant_q;
    for (int i = 0; i < 2; i++) begin
      if (!pend_valid_q[i] && m_strobe[i]) begin
        pend_valid_d[i] = 1'b1;
        pend_write_d[i] = |m_wmask[i];
        pend_addr_d[i]  = m_addr[i];
        pend_wdata_d[i] = m_wdata[i];
        pend_wmask_d[i] = m_wmask[i];
      end
    end
    if (issue) begin
      last_grant_d = winner;
      if (pend_write_q[winner]) begin
        pend_valid_d[winner] = 1'b0;
      end
    end
    if (state_q == RESP) begin
      pend_valid_d[resp_id_q] = 1'b0;
      rdata_d[resp_id_q]      = ram_rdata;
    end
  end

  always_comb begin
    ram_addr  = pend_addr_q[winner];
    ram_wdata = pend_wdata_q[winner];
    ram_wmask = 4'b0000;
    ram_rstrb = 1'b0;
    if (resetn && issue) begin
      if (pend_write_q[winner]) begin
        ram_wmask = pend_wmask_q[winner];
      end else begin
        ram_rstrb = 1'b1;
      end
    end
  end

  assign m0.rdata = rdata_q[0];
  assign m1.rdata = rdata_q[1];
  assign m0.rbusy = pend_valid_q[0] & ~pend_write_q[0];
  assign m0.wbusy = pend_valid_q[0] &  pend_write_q[0];
  assign m1.rbusy = pend_valid_q[1] & ~pend_write_q[1];
  assign m1.wbusy = pend_valid_q[1] &  pend_write_q[1];

endmodule
